// File: rtl/commit_trace_ctrl_if.sv
// Commit/trace handshake bundle between the WB stage, the commit trace controller and the
// DPI trace/difftest sink. The controller uses the slave view; the environment uses the master view.
interface commit_trace_ctrl_if #(
    parameter int XLEN = 64
);
    logic            cmt_valid;
    logic            cmt_ready;
    logic [XLEN-1:0] cmt_pc;
    logic [31:0]     cmt_inst;
    logic            cmt_wen;
    logic [4:0]      cmt_rd;
    logic [XLEN-1:0] cmt_wdata;
    logic            cmt_skip;
    logic            cmt_ebreak;
    logic [XLEN-1:0] cmt_a0;

    logic            trc_valid;
    logic            trc_ready;
    logic [XLEN-1:0] trc_pc;
    logic [31:0]     trc_inst;
    logic            trc_wen;
    logic [4:0]      trc_rd;
    logic [XLEN-1:0] trc_wdata;
    logic            trc_skip;

    modport master (
        output cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_rd, cmt_wdata,
               cmt_skip, cmt_ebreak, cmt_a0, trc_ready,
        input  cmt_ready, trc_valid, trc_pc, trc_inst, trc_wen, trc_rd,
               trc_wdata, trc_skip
    );

    modport slave (
        input  cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_rd, cmt_wdata,
               cmt_skip, cmt_ebreak, cmt_a0, trc_ready,
        output cmt_ready, trc_valid, trc_pc, trc_inst, trc_wen, trc_rd,
               trc_wdata, trc_skip
    );
endinterface

// File: rtl/commit_trace_ctrl.sv
// Buffers retired-instruction commits for the trace/difftest sink, detects ebreak end-of-simulation
// (draining the buffer before reporting done) and runs a commit watchdog for hung cores.
module commit_trace_ctrl #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                clock,
    input  logic                reset,
    commit_trace_ctrl_if.slave  bus,
    output logic [63:0]         commit_cnt,
    output logic                done,
    output logic                done_good,
    output logic                timeout
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]   ONE_CNT  = CW'(1);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            wen;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
        logic            skip;
    } entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head;

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [WD_W-1:0] wdog;
    logic            good;
    logic            tmo_flag;

    logic            cmt_rdy;
    logic            enq;
    logic            deq;
    logic            wd_fire;

    function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
        if (v >= WD_MAX) begin
            return WD_MAX;
        end
        return v + 1'b1;
    endfunction

    assign enq = bus.cmt_valid && cmt_rdy;
    assign deq = bus.trc_valid && bus.trc_ready;

    // A commit arriving in the firing cycle counts as progress, so an ebreak beats the watchdog.
    assign wd_fire = (TIMEOUT != 0) && (state == RUN) && !enq && (wdog == WD_LAST);

    // An rd of x0 never produces an architectural write, whatever the WB stage claims.
    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = bus.cmt_pc;
        wr_entry.inst  = bus.cmt_inst;
        wr_entry.wen   = bus.cmt_wen && (bus.cmt_rd != 5'd0);
        wr_entry.rd    = bus.cmt_rd;
        wr_entry.wdata = bus.cmt_wdata;
        wr_entry.skip  = bus.cmt_skip;
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // First-word fall-through: the sink sees the head entry directly from storage.
    assign head          = mem[rd_ptr];
    assign bus.trc_valid = (count != '0);
    assign bus.trc_pc    = head.pc;
    assign bus.trc_inst  = head.inst;
    assign bus.trc_wen   = head.wen;
    assign bus.trc_rd    = head.rd;
    assign bus.trc_wdata = head.wdata;
    assign bus.trc_skip  = head.skip;
    assign bus.cmt_ready = cmt_rdy;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            commit_cnt <= '0;
            wdog       <= '0;
            good       <= 1'b0;
            tmo_flag   <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr     <= rd_ptr + 1'b1;
                commit_cnt <= commit_cnt + 64'd1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (enq) begin
                wdog <= '0;
            end else if (state == RUN) begin
                wdog <= wd_sat_inc(wdog);
            end
            if ((state == RUN) && enq && bus.cmt_ebreak) begin
                good <= (bus.cmt_a0 == '0);
            end
            if (wd_fire) begin
                tmo_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (enq && bus.cmt_ebreak) begin
                    state_nxt = DRAIN;
                end else if (wd_fire) begin
                    state_nxt = DONE;
                end
            end
            DRAIN: begin
                if (deq && (count == ONE_CNT)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    // Residual entries left by a watchdog stop keep draining in DONE; only acceptance stops.
    always_comb begin
        cmt_rdy   = 1'b0;
        done      = 1'b0;
        done_good = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            RUN:   cmt_rdy = (count < FULL_CNT);
            DRAIN: cmt_rdy = 1'b0;
            DONE: begin
                done      = 1'b1;
                done_good = good;
                timeout   = tmo_flag;
            end
            default: cmt_rdy = 1'b0;
        endcase
    end

endmodule
